dot_accum_ctrl: RTL and testbench

DOT_ACCUM_CTRL -- requirements
Module: dot_accum_ctrl

---
 rtl/gemm_acc_pkg.sv | 19 +
 rtl/adder_4in.sv | 15 +
 rtl/dot_accum_ctrl.sv | 126 ++++++++++++
 tb/tb_dot_accum_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gemm_acc_pkg.sv
// Shared types and width helpers for the dot-product accumulator.
// Optional saturating accumulation is selected by DOT_ACCUM_SAT_EN (see dot_accum_ctrl).
package gemm_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

  function automatic int lane_width(input int sig_width, input int low_expand);
    return sig_width + 4 + low_expand;
  endfunction

  function automatic int acc_width(input int sig_width, input int low_expand, input int acc_ext);
    return lane_width(sig_width, low_expand) + acc_ext;
  endfunction

endpackage

// File: rtl/adder_4in.sv
// Four-lane unsigned adder; the result wraps modulo 2^W (carry out is dropped).
module adder_4in
  import gemm_acc_pkg::*;
#(
  parameter int sigWidth   = 4,
  parameter int low_expand = 2,
  localparam int W = lane_width(sigWidth, low_expand)
) (
  input  logic [4*W-1:0] lanes_i,
  output logic [W-1:0]   sum_o
);

  assign sum_o = lanes_i[W-1:0] + lanes_i[2*W-1:W] + lanes_i[3*W-1:2*W] + lanes_i[4*W-1:3*W];

endmodule

// File: rtl/dot_accum_ctrl.sv
// Beat-serial dot-product accumulator with valid/ready in and out.
// Build option DOT_ACCUM_SAT_EN: saturating accumulation with a sticky out_sat flag.
//   state    | meaning
//   ST_IDLE  | waiting for the first beat of a dot product
//   ST_ACCUM | adding further beats until the latched beat count is reached
//   ST_DONE  | result held on out_significand until the consumer takes it
module dot_accum_ctrl
  import gemm_acc_pkg::*;
#(
  parameter int sigWidth   = 4,
  parameter int low_expand = 2,
  parameter int MAX_BEATS  = 8,
  parameter int ACC_EXT    = 1,
  localparam int W  = lane_width(sigWidth, low_expand),
  localparam int AW = acc_width(sigWidth, low_expand, ACC_EXT),
  localparam int BW = $clog2(MAX_BEATS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [BW-1:0]  cfg_beats,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_sigOffset,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_significand,
  output logic           out_sat
);

  acc_state_e    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] cfg_q, cfg_d;
  logic [W-1:0]  lane_sum;
  logic [AW-1:0] lane_ext;
  logic [AW-1:0] acc_add;
  logic          accept;

  adder_4in #(
    .sigWidth  (sigWidth),
    .low_expand(low_expand)
  ) u_adder (
    .lanes_i(in_sigOffset),
    .sum_o  (lane_sum)
  );

  assign lane_ext  = AW'(lane_sum);
  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign out_significand = acc_q;

`ifdef DOT_ACCUM_SAT_EN
  logic [AW:0] sum_wide;
  logic        sat_q;

  assign sum_wide = {1'b0, acc_q} + {1'b0, lane_ext};
  assign acc_add  = sum_wide[AW] ? {AW{1'b1}} : sum_wide[AW-1:0];
  assign out_sat  = sat_q;

  // Sticky per dot product: cleared on its first beat, set by any clipped add.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sat_q <= 1'b0;
    end else if (accept && state_q == ST_IDLE) begin
      sat_q <= 1'b0;
    end else if (accept && state_q == ST_ACCUM && sum_wide[AW]) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign acc_add = acc_q + lane_ext;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    // Flush outranks both the input beat and the output handshake.
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cfg_d   = cfg_beats;
            acc_d   = lane_ext;
            cnt_d   = '0;
            state_d = (cfg_beats == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_d = acc_add;
            cnt_d = cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == cfg_q) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum_ctrl.sv
// Directed bench for dot_accum_ctrl: vector table of dot products plus stall/flush/reset sequences.
module tb_dot_accum_ctrl;

  localparam int W  = 10;
  localparam int AW = 11;
  localparam int BW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [BW-1:0]  cfg_beats;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_sigOffset;
  logic           out_valid;
  logic           out_ready;
  logic [AW-1:0]  out_significand;
  logic           out_sat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string nm;
    int    cfg;
    int    l0, l1, l2, l3;
    int    exp_val;
    int    exp_sat;
  } vec_t;

  vec_t vecs[6];

  dot_accum_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .cfg_beats      (cfg_beats),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sigOffset   (in_sigOffset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_significand(out_significand),
    .out_sat        (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [4*W-1:0] p;
    p = {W'(d), W'(c), W'(b), W'(a)};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full dot product; cfg_beats is scrambled after the first beat to prove it was latched.
  task automatic run_dp(input string nm, input int cfg, input int l0, input int l1,
                        input int l2, input int l3, input int exp_val, input int exp_sat);
    cfg_beats    = BW'(cfg);
    in_sigOffset = pack(l0, l1, l2, l3);
    in_valid     = 1'b1;
    for (int b = 0; b <= cfg; b++) begin
      chk({nm, "_in_ready"}, int'(in_ready), 1);
      chk({nm, "_no_early_valid"}, int'(out_valid), 0);
      tick();
      cfg_beats = BW'((cfg + 5) % 8);
    end
    in_valid = 1'b0;
    chk({nm, "_out_valid"}, int'(out_valid), 1);
    chk({nm, "_value"}, int'(out_significand), exp_val);
    chk({nm, "_sat"}, int'(out_sat), exp_sat);
    chk({nm, "_busy"}, int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_released"}, int'(out_valid), 0);
    chk({nm, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{nm: "basic",    cfg: 0, l0: 1,    l1: 2,    l2: 3, l3: 4,  exp_val: 10,   exp_sat: 0};
    vecs[1] = '{nm: "four_100", cfg: 3, l0: 100,  l1: 100,  l2: 100, l3: 100, exp_val: 1600, exp_sat: 0};
    vecs[2] = '{nm: "lanewrap", cfg: 0, l0: 1023, l1: 1023, l2: 1, l3: 1,  exp_val: 0,    exp_sat: 0};
`ifdef DOT_ACCUM_SAT_EN
    vecs[3] = '{nm: "accover",  cfg: 7, l0: 250,  l1: 250,  l2: 250, l3: 250, exp_val: 2047, exp_sat: 1};
`else
    vecs[3] = '{nm: "accover",  cfg: 7, l0: 250,  l1: 250,  l2: 250, l3: 250, exp_val: 1856, exp_sat: 0};
`endif
    vecs[4] = '{nm: "two_beat", cfg: 1, l0: 5,    l1: 0,    l2: 0, l3: 0,  exp_val: 10,   exp_sat: 0};
    vecs[5] = '{nm: "three",    cfg: 2, l0: 7,    l1: 8,    l2: 9, l3: 10, exp_val: 102,  exp_sat: 0};

    rst = 1'b1; flush = 1'b0; cfg_beats = '0; in_valid = 1'b0;
    in_sigOffset = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_value", int'(out_significand), 0);
    chk("rst_sat", int'(out_sat), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_dp(vecs[i].nm, vecs[i].cfg, vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3,
             vecs[i].exp_val, vecs[i].exp_sat);

    // Result stalled for 3 cycles while another beat is offered and must be ignored.
    cfg_beats = 3'd0; in_sigOffset = pack(3, 3, 3, 3); in_valid = 1'b1;
    tick();
    in_sigOffset = pack(9, 9, 9, 9);
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_value", int'(out_significand), 12);
      chk("stall_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_dp("after_stall", 0, 5, 0, 0, 0, 5, 0);

    // Flush after two beats, with a third beat offered in the flush cycle.
    cfg_beats = 3'd3; in_sigOffset = pack(1, 1, 1, 1); in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_ready", int'(in_ready), 1);
    chk("flush_acc_clear", int'(out_significand), 0);
    for (int c = 0; c < 5; c++) begin
      chk("flush_no_output", int'(out_valid), 0);
      tick();
    end
    run_dp("after_flush", 0, 2, 2, 2, 2, 8, 0);

    // Flush wins over the output handshake and discards a held result.
    cfg_beats = 3'd0; in_sigOffset = pack(4, 4, 4, 4); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("done_before_flush", int'(out_valid), 1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("done_flushed_valid", int'(out_valid), 0);
    chk("done_flushed_value", int'(out_significand), 0);

    // Reset in the middle of accumulation, asserted together with flush.
    cfg_beats = 3'd3; in_sigOffset = pack(50, 50, 50, 50); in_valid = 1'b1;
    tick(); tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("midrst_value", int'(out_significand), 0);
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_valid", int'(out_valid), 0);
    run_dp("after_rst", 1, 6, 0, 0, 0, 12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
